ads7883_emu: RTL and testbench
==============================

// Module: ads7883_emu
// PURPOSE
//  SPI responder that emulates the ADS7883 12-bit ADC for hardware-in-the-loop test of the neck-detection chain.
//  It is driven by the ADS7883 controller's sclk/ncs, serialises buffered 12-bit samples on sdo, and replaces the real ADC.
//  A test source supplies samples through a 2-entry valid/ready buffer (e.g. a recorded weld current trace).
// PARAMETERS
//  SYNC_STAGES  2       synchroniser flops on ads7883_sclk / ads7883_ncs (>=2)
//  LEAD_ZEROS   2       zero bits sent before the MSB
//  FRAME_BITS   16      sclk falling edges per complete frame (LEAD_ZEROS+12+trailing zeros)
//  IDLE_VALUE   12'h000 sample sent on underrun before any sample has ever been accepted
// PORTS
//  clk             in   1   system clock, single domain
//  rst             in   1   synchronous, active-high reset
//  s_data          in   12  sample to emulate, straight binary
//  s_valid         in   1   s_data valid
//  s_ready         out  1   buffer not full; push occurs when s_valid & s_ready
//  ads7883_sclk    in   1   SPI clock from controller (async to clk, synchronised)
//  ads7883_ncs     in   1   chip select, active low (async, synchronised)
//  ads7883_sdo     out  1   serial data to controller
//  ads7883_sdo_oe  out  1   1 while ncs low (emulates tri-state; sdo=1 when 0)
//  frame_done      out  1   1-clk pulse: full frame of FRAME_BITS edges completed
//  frame_abort     out  1   1-clk pulse: ncs rose before frame complete
//  underrun        out  1   1-clk pulse: frame started with empty buffer
//  frame_cnt       out  16  count of completed frames, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: sdo=1, sdo_oe=0, s_ready=1, pulses 0, frame_cnt=0, buffer flushed, last_sample=IDLE_VALUE,
//   synchronisers preset to 1 (ncs high, sclk high), state IDLE.
//  Edge detect on synchronised signals; response to a pin edge appears SYNC_STAGES+1 clk later.
//   Controller sclk half-period must be >= SYNC_STAGES+2 clk; shorter is unsupported.
//  FSM IDLE -> SHIFT -> HOLD:
//   IDLE: sdo_oe=0, sdo=1. ncs falling: pop buffer head into shreg and last_sample; if empty load
//    last_sample and pulse underrun; bit_idx=0, sdo=bit 0, sdo_oe=1 -> SHIFT.
//    Only a falling edge starts a frame: ncs already low at reset release is ignored.
//   SHIFT: each sclk falling edge: bit_idx+1, sdo=frame bit[bit_idx+1].
//    Frame bits: idx 0..LEAD_ZEROS-1 = 0; next 12 = D11..D0 MSB first; remaining = 0.
//    FRAME_BITS-th falling edge -> HOLD, pulse frame_done, frame_cnt+1, sdo=0.
//    ncs rising in SHIFT -> pulse frame_abort, frame_cnt unchanged, -> IDLE. Aborted sample is consumed.
//   HOLD: sdo=0 on further sclk edges; ncs rising -> IDLE.
//  ncs rise and sclk fall in the same clk: ncs wins, sclk edge ignored.
//  sclk edges while IDLE are ignored.
//  Buffer: 2 entries; s_ready = !full.
//   Push and pop in the same clk when empty: pop sees empty (underrun, no bypass); pushed entry stays.
//   Push and pop in the same clk with 1 entry: both occur.
//  rst mid-frame: outputs go to reset values on the next clk; a new frame needs a fresh ncs falling edge.
// TESTING
//  1 Push 12'hA5C; 16-sclk frame -> controller captures 16'h2970; frame_done once; frame_cnt=1; underrun=0.
//  2 Push 0x001, 0xFFF; third push stalls (s_ready=0); two frames -> 16'h0004 then 16'h3FFC; s_ready=1 after first ncs fall.
//  3 No push after reset; frame -> 16'h0000 with underrun pulse. Push 0x800; frame -> 16'h2000.
//    Next frame with empty buffer -> 16'h2000 again with underrun.
//  4 Push 0x123, 0x456; raise ncs after 7 sclk falls -> frame_abort pulse, frame_cnt unchanged; next frame -> 16'h1158 (0x456).
//  5 Assert rst at bit 8 with ncs held low -> sdo_oe=0 next clk, frame_cnt=0, s_ready=1.
//    No sdo_oe until ncs high then low; push 0x0F0 -> 16'h03C0.

Source files
------------

// File: rtl/ads7883_emu.sv
// ADS7883 12-bit ADC emulator: SPI responder fed from a 2-entry sample buffer.
// Pin inputs are asynchronous and synchronised; all logic runs on clk.
module ads7883_emu #(
  parameter int          SYNC_STAGES = 2,
  parameter int          LEAD_ZEROS  = 2,
  parameter int          FRAME_BITS  = 16,
  parameter logic [11:0] IDLE_VALUE  = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        ads7883_sclk,
  input  logic        ads7883_ncs,
  output logic        ads7883_sdo,
  output logic        ads7883_sdo_oe,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam int DATA_W = 12;
  localparam int IDX_W  = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_W-1:0] sample);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[FRAME_BITS-1-LEAD_ZEROS -: DATA_W] = sample;
    return w;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, flush;
  logic                   sclk_d, ncs_d, armed;
  logic                   sclk_s, ncs_s, sclk_fall, ncs_fall, ncs_rise;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       bit_idx;
  logic [FRAME_BITS-1:0]  shreg;
  logic [DATA_W-1:0]      last_sample;
  logic [DATA_W-1:0]      buf_q [2];
  logic [1:0]             buf_cnt;
  logic                   buf_empty, buf_full, push, pop, pop_req;
  logic                   load, shift, done_nxt, abort_nxt, under_nxt;

  // Synchroniser and edge detect; presets read as ncs/sclk high
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '1;
      ncs_sync  <= '1;
      flush     <= '0;
      sclk_d    <= 1'b1;
      ncs_d     <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ads7883_sclk};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ads7883_ncs};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      ncs_d     <= ncs_s;
      // A frame may only start once ncs has genuinely been seen high since reset
      armed     <= armed | (flush[SYNC_STAGES-1] & ncs_s);
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign ncs_fall  = armed & ncs_d & ~ncs_s;
  assign ncs_rise  = ~ncs_d & ncs_s;

  // Sample buffer
  assign buf_empty = (buf_cnt == 2'd0);
  assign buf_full  = (buf_cnt == 2'd2);
  assign s_ready   = ~buf_full;
  assign push      = s_valid & ~buf_full;
  assign pop       = pop_req & ~buf_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt <= 2'd0;
    end else if (push && !pop) begin
      buf_cnt <= buf_cnt + 2'd1;
    end else if (pop && !push) begin
      buf_cnt <= buf_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      buf_q[0] <= push ? s_data : buf_q[1];
    end else if (push) begin
      buf_q[buf_cnt[0]] <= s_data;
    end
  end

  // Frame FSM
  always_comb begin
    state_nxt      = state;
    pop_req        = 1'b0;
    load           = 1'b0;
    shift          = 1'b0;
    done_nxt       = 1'b0;
    abort_nxt      = 1'b0;
    under_nxt      = 1'b0;
    ads7883_sdo    = 1'b1;
    ads7883_sdo_oe = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          pop_req   = 1'b1;
          load      = 1'b1;
          under_nxt = buf_empty;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ads7883_sdo    = shreg[FRAME_BITS-1];
        ads7883_sdo_oe = 1'b1;
        if (ncs_rise) begin
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_fall) begin
          if (bit_idx == LAST_IDX) begin
            done_nxt  = 1'b1;
            state_nxt = HOLD;
          end else begin
            shift = 1'b1;
          end
        end
      end
      HOLD: begin
        ads7883_sdo    = 1'b0;
        ads7883_sdo_oe = 1'b1;
        if (ncs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= frame_word(buf_empty ? last_sample : buf_q[0]);
    end else if (shift) begin
      shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_idx     <= '0;
      last_sample <= IDLE_VALUE;
      frame_cnt   <= 16'd0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        bit_idx <= '0;
      end else if (shift) begin
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (pop) last_sample <= buf_q[0];
      if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
      frame_done  <= done_nxt;
      frame_abort <= abort_nxt;
      underrun    <= under_nxt;
    end
  end

endmodule

// File: tb/tb_ads7883_emu.sv
// Bench for ads7883_emu: SPI controller model, buffer reference model and
// a scoreboard monitor that checks every completed or aborted frame.
module tb_ads7883_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] s_data = 12'h000;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        sclk = 1'b1;
  logic        ncs = 1'b1;
  logic        sdo, sdo_oe, frame_done, frame_abort, underrun;
  logic [15:0] frame_cnt;

  ads7883_emu dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ads7883_sclk  (sclk),
    .ads7883_ncs   (ncs),
    .ads7883_sdo   (sdo),
    .ads7883_sdo_oe(sdo_oe),
    .frame_done    (frame_done),
    .frame_abort   (frame_abort),
    .underrun      (underrun),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    bit          under;
    bit          abort;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [11:0] model_buf[$];
  logic [11:0] model_last;
  logic [15:0] model_cnt;
  logic [15:0] cap_word;
  int          under_seen;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [11:0] d);
    bit acc;
    acc = (model_buf.size() < 2);
    s_data  = d;
    s_valid = 1'b1;
    check("s_ready_on_push", 16'(s_ready), 16'(acc));
    wait_clks(1);
    s_valid = 1'b0;
    if (acc) model_buf.push_back(d);
  endtask

  // Controller: samples sdo just before each sclk falling edge
  task automatic run_frame(input int nfalls, input int half);
    exp_t        e;
    logic [11:0] smp;
    if (model_buf.size() > 0) begin
      smp        = model_buf.pop_front();
      model_last = smp;
      e.under    = 1'b0;
    end else begin
      smp     = model_last;
      e.under = 1'b1;
    end
    e.word  = 16'({4'h0, smp}) * 16'd4;
    e.abort = (nfalls < 16);
    if (!e.abort) model_cnt = model_cnt + 16'd1;
    e.cnt = model_cnt;
    exp_q.push_back(e);
    cap_word = 16'h0000;
    ncs = 1'b0;
    wait_clks(half);
    check("s_ready_after_ncs_fall", 16'(s_ready), 16'(model_buf.size() < 2));
    check("sdo_oe_in_frame", 16'(sdo_oe), 16'd1);
    for (int i = 0; i < nfalls; i++) begin
      cap_word = {cap_word[14:0], sdo};
      sclk = 1'b0;
      wait_clks(half);
      sclk = 1'b1;
      wait_clks(half);
    end
    ncs = 1'b1;
    wait_clks(half + 2);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      under_seen = 0;
    end else begin
      if (underrun) under_seen++;
      if (frame_done || frame_abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_end", 16'd1, 16'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_end_is_abort", 16'(frame_abort), 16'(mon_e.abort));
          check("underrun_pulse", 16'(under_seen != 0), 16'(mon_e.under));
          if (!mon_e.abort) check("frame_word", cap_word, mon_e.word);
          check("frame_cnt", frame_cnt, mon_e.cnt);
        end
        under_seen = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    model_last = 12'h000;
    model_cnt  = 16'd0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(10);
    check("rst_sdo", 16'(sdo), 16'd1);
    check("rst_sdo_oe", 16'(sdo_oe), 16'd0);
    check("rst_s_ready", 16'(s_ready), 16'd1);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_pulses", 16'({frame_done, frame_abort, underrun}), 16'd0);

    // Underrun before any sample, then last-sample repeat on underrun
    run_frame(16, 6);
    push(12'h800);
    run_frame(16, 6);
    run_frame(16, 4);

    push(12'hA5C);
    run_frame(16, 5);

    // Buffer fill and stall
    push(12'h001);
    push(12'hFFF);
    push(12'h555);
    run_frame(16, 4);
    run_frame(16, 4);

    // Abort consumes the sample
    push(12'h123);
    push(12'h456);
    run_frame(7, 5);
    run_frame(16, 5);

    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) push(12'($urandom_range(0, 4095)));
      if ($urandom_range(0, 4) == 0) run_frame($urandom_range(1, 15), $urandom_range(4, 6));
      else run_frame(16, $urandom_range(4, 6));
    end

    // Reset mid-frame with ncs held low
    push(12'h3A7);
    ncs = 1'b0;
    wait_clks(5);
    repeat (8) begin
      sclk = 1'b0;
      wait_clks(5);
      sclk = 1'b1;
      wait_clks(5);
    end
    rst = 1'b1;
    wait_clks(1);
    check("midrst_sdo_oe", 16'(sdo_oe), 16'd0);
    check("midrst_frame_cnt", frame_cnt, 16'd0);
    check("midrst_s_ready", 16'(s_ready), 16'd1);
    wait_clks(1);
    rst = 1'b0;
    model_buf.delete();
    model_last = 12'h000;
    model_cnt  = 16'd0;
    wait_clks(20);
    check("no_oe_ncs_low_after_rst", 16'(sdo_oe), 16'd0);
    ncs = 1'b1;
    wait_clks(6);
    push(12'h0F0);
    run_frame(16, 5);

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      wait_clks(1);
      w++;
    end
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
